// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I control unit:
// FSM states, opcodes, ALU op/control and datapath mux selects.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps alu_op and instruction fields to alu_control.
// Purely combinational.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type distinguishes sub; addi reuses bit 30 as imm
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
// Define MULTICYCLE_CTRL_MEM_WAIT_EN for mem_ready wait states and timeout.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             reg_write,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instret
);

  state_t     state;
  state_t     state_n;
  logic [1:0] alu_op;
  logic [2:0] alu_ctl;
  logic       pc_w;
  logic       adr_s;
  logic       mem_w;
  logic       ir_w;
  logic       reg_w;
  logic [1:0] res_s;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic       illegal_set;
  logic       timeout_set;
  logic       ready;
  logic       wait_hit;
  logic       retire;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  localparam int WW = $clog2(MEM_WAIT_MAX + 1);

  logic [WW-1:0] wait_cnt;

  assign ready    = mem_ready;
  assign wait_hit = !mem_ready &&
                    (wait_cnt == WW'(MEM_WAIT_MAX - 1));

  // counts waiting cycles spent in the current state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state_n != state) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end
`else
  logic unused_ok;

  assign unused_ok = mem_ready & (MEM_WAIT_MAX > 0);
  assign ready     = 1'b1;
  assign wait_hit  = 1'b0;
`endif

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_ctl)
  );

  always_comb begin
    state_n     = state;
    pc_w        = 1'b0;
    adr_s       = 1'b0;
    mem_w       = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    res_s       = RES_ALUOUT;
    src_a       = SRCA_PC;
    src_b       = SRCB_WD;
    alu_op      = ALUOP_ADD;
    illegal_set = 1'b0;
    timeout_set = 1'b0;
    unique case (state)
      S_FETCH: begin
        src_b = SRCB_FOUR;
        res_s = RES_ALURES;
        if (ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_n = S_DECODE;
        end else if (wait_hit) begin
          timeout_set = 1'b1;
          state_n     = S_TRAP;
        end
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (op)
          OP_LOAD,
          OP_STORE: state_n = S_MEMADR;
          OP_RTYPE: state_n = S_EXECR;
          OP_ITYPE: state_n = S_EXECI;
          OP_BEQ:   state_n = S_BEQ;
          OP_JAL:   state_n = S_JAL;
          default: begin
            illegal_set = 1'b1;
            state_n     = S_TRAP;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_A;
        src_b   = SRCB_IMM;
        state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_s = 1'b1;
        if (ready) begin
          state_n = S_MEMWB;
        end else if (wait_hit) begin
          timeout_set = 1'b1;
          state_n     = S_TRAP;
        end
      end
      S_MEMWB: begin
        res_s   = RES_RDATA;
        reg_w   = 1'b1;
        state_n = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_s = 1'b1;
        mem_w = 1'b1;
        if (ready) begin
          state_n = S_FETCH;
        end else if (wait_hit) begin
          timeout_set = 1'b1;
          state_n     = S_TRAP;
        end
      end
      S_EXECR: begin
        src_a   = SRCA_A;
        src_b   = SRCB_WD;
        alu_op  = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = SRCA_A;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_n = S_FETCH;
      end
      S_BEQ: begin
        src_a   = SRCA_A;
        src_b   = SRCB_WD;
        alu_op  = ALUOP_SUB;
        pc_w    = zero;
        state_n = S_FETCH;
      end
      S_JAL: begin
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_FOUR;
        pc_w    = 1'b1;
        state_n = S_ALUWB;
      end
      S_TRAP: state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
  end

  assign retire = (state_n == S_FETCH) &&
                  (state != S_FETCH) &&
                  (state != S_TRAP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
      instret     <= '0;
    end else begin
      state <= state_n;
      if (illegal_set) illegal <= 1'b1;
      if (timeout_set) mem_timeout <= 1'b1;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  // reset forces every strobe low, including FETCH's
  assign pc_write    = rst & pc_w;
  assign adr_src     = rst & adr_s;
  assign mem_write   = rst & mem_w;
  assign ir_write    = rst & ir_w;
  assign reg_write   = rst & reg_w;
  assign result_src  = rst ? res_s : 2'b00;
  assign alu_src_a   = rst ? src_a : 2'b00;
  assign alu_src_b   = rst ? src_b : 2'b00;
  assign alu_control = rst ? alu_ctl : 3'b000;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table
// plus trap, reset-abort and (when enabled) memory-wait sequences.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  op = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;

  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  alu_control;
  logic        illegal, mem_timeout;
  logic [31:0] instret;

  logic        w_pc_write, w_adr_src, w_mem_write, w_ir_write;
  logic        w_reg_write, w_illegal, w_mem_timeout;
  logic [1:0]  w_result_src, w_alu_src_a, w_alu_src_b;
  logic [2:0]  w_alu_control;
  logic [1:0]  w_instret;

  logic [13:0] outs;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(32), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .reg_write(reg_write),
    .illegal(illegal), .mem_timeout(mem_timeout), .instret(instret)
  );

  // narrow counter instance to exercise wrap-around
  multicycle_controller #(.CNT_W(2), .MEM_WAIT_MAX(15)) u_w (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(w_pc_write), .adr_src(w_adr_src),
    .mem_write(w_mem_write), .ir_write(w_ir_write),
    .result_src(w_result_src), .alu_src_a(w_alu_src_a),
    .alu_src_b(w_alu_src_b), .alu_control(w_alu_control),
    .reg_write(w_reg_write), .illegal(w_illegal),
    .mem_timeout(w_mem_timeout), .instret(w_instret)
  );

  assign outs = {pc_write, adr_src, mem_write, ir_write, result_src,
                 alu_src_a, alu_src_b, alu_control, reg_write};

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [13:0] e;
    int unsigned n;
  } vec_t;

  vec_t        tv[$];
  int unsigned n;
  int          checks = 0;
  int          errors = 0;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;

  function automatic logic [13:0] pk(
    logic pw, logic adr, logic mw, logic ir, logic [1:0] res,
    logic [1:0] a, logic [1:0] b, logic [2:0] alu, logic rw);
    return {pw, adr, mw, ir, res, a, b, alu, rw};
  endfunction

  logic [13:0] OF, OD, OWB, OMA, OMR, OMW, OMB;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] op_i, input logic [2:0] f3_i,
                     input logic f7_i, input logic z_i,
                     input logic [13:0] e_i);
    vec_t v;
    v.op = op_i;
    v.f3 = f3_i;
    v.f7 = f7_i;
    v.z  = z_i;
    v.e  = e_i;
    v.n  = n;
    tv.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    OF  = pk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    OD  = pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
    OWB = pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1);
    OMA = pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    OMR = pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    OMW = pk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    OMB = pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1);

    n = 0;
    // add x3,x1,x2
    add(RT, 3'b000, 0, 0, OF);
    add(RT, 3'b000, 0, 0, OD);
    add(RT, 3'b000, 0, 0, pk(0, 0, 0, 0, 0, 2, 0, 3'b000, 0));
    add(RT, 3'b000, 0, 0, OWB); n++;
    // sub
    add(RT, 3'b000, 1, 0, OF);
    add(RT, 3'b000, 1, 0, OD);
    add(RT, 3'b000, 1, 0, pk(0, 0, 0, 0, 0, 2, 0, 3'b001, 0));
    add(RT, 3'b000, 1, 0, OWB); n++;
    // sw
    add(ST, 3'b010, 0, 0, OF);
    add(ST, 3'b010, 0, 0, OD);
    add(ST, 3'b010, 0, 0, OMA);
    add(ST, 3'b010, 0, 0, OMW); n++;
    // lw
    add(LD, 3'b010, 0, 0, OF);
    add(LD, 3'b010, 0, 0, OD);
    add(LD, 3'b010, 0, 0, OMA);
    add(LD, 3'b010, 0, 0, OMR);
    add(LD, 3'b010, 0, 0, OMB); n++;
    // beq taken
    add(BQ, 3'b000, 0, 1, OF);
    add(BQ, 3'b000, 0, 1, OD);
    add(BQ, 3'b000, 0, 1, pk(1, 0, 0, 0, 0, 2, 0, 3'b001, 0)); n++;
    // beq not taken
    add(BQ, 3'b000, 0, 0, OF);
    add(BQ, 3'b000, 0, 0, OD);
    add(BQ, 3'b000, 0, 0, pk(0, 0, 0, 0, 0, 2, 0, 3'b001, 0)); n++;
    // addi with imm bit 30 set stays add
    add(IT, 3'b000, 1, 0, OF);
    add(IT, 3'b000, 1, 0, OD);
    add(IT, 3'b000, 1, 0, pk(0, 0, 0, 0, 0, 2, 1, 3'b000, 0));
    add(IT, 3'b000, 1, 0, OWB); n++;
    // slt
    add(RT, 3'b010, 0, 0, OF);
    add(RT, 3'b010, 0, 0, OD);
    add(RT, 3'b010, 0, 0, pk(0, 0, 0, 0, 0, 2, 0, 3'b101, 0));
    add(RT, 3'b010, 0, 0, OWB); n++;
    // or
    add(RT, 3'b110, 0, 0, OF);
    add(RT, 3'b110, 0, 0, OD);
    add(RT, 3'b110, 0, 0, pk(0, 0, 0, 0, 0, 2, 0, 3'b011, 0));
    add(RT, 3'b110, 0, 0, OWB); n++;
    // andi
    add(IT, 3'b111, 0, 0, OF);
    add(IT, 3'b111, 0, 0, OD);
    add(IT, 3'b111, 0, 0, pk(0, 0, 0, 0, 0, 2, 1, 3'b010, 0));
    add(IT, 3'b111, 0, 0, OWB); n++;
    // sll falls back to add
    add(RT, 3'b001, 0, 0, OF);
    add(RT, 3'b001, 0, 0, OD);
    add(RT, 3'b001, 0, 0, pk(0, 0, 0, 0, 0, 2, 0, 3'b000, 0));
    add(RT, 3'b001, 0, 0, OWB); n++;
    // jal
    add(JL, 3'b000, 0, 0, OF);
    add(JL, 3'b000, 0, 0, OD);
    add(JL, 3'b000, 0, 0, pk(1, 0, 0, 0, 0, 1, 2, 3'b000, 0));
    add(JL, 3'b000, 0, 0, OWB); n++;

    // reset state
    #12;
    chk("reset_outs", outs, 0);
    chk("reset_instret", instret, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_timeout", mem_timeout, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      op       = tv[i].op;
      funct3   = tv[i].f3;
      funct7b5 = tv[i].f7;
      zero     = tv[i].z;
      #1;
      chk($sformatf("row%0d_outs", i), outs, tv[i].e);
      chk($sformatf("row%0d_instret", i), instret, tv[i].n);
      chk($sformatf("row%0d_wrap", i), w_instret, 2'(tv[i].n));
      cyc();
    end

    // illegal opcode traps and holds
    op = 7'b1111111; funct3 = 0; funct7b5 = 0; zero = 0;
    #1;
    chk("trap_fetch", outs, OF);
    chk("trap_instret", instret, n);
    chk("pre_illegal", illegal, 0);
    cyc();
    chk("trap_decode", outs, OD);
    cyc();
    chk("trap_outs", outs, 0);
    chk("trap_illegal", illegal, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("trap_hold", outs, 0);
      chk("trap_hold_instret", instret, n);
    end
    rst = 1'b0;
    #1;
    chk("trap_rst_outs", outs, 0);
    chk("trap_rst_instret", instret, 0);
    chk("trap_rst_illegal", illegal, 0);
    cyc();
    chk("trap_rst_hold", outs, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("trap_release_fetch", outs, OF);

    // reset asserted mid-MEMWRITE
    op = ST; funct3 = 3'b010;
    cyc();
    chk("abort_decode", outs, OD);
    cyc();
    chk("abort_memadr", outs, OMA);
    cyc();
    chk("abort_memwrite", outs, OMW);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_drop", outs, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_fetch", outs, OF);
    chk("abort_instret", instret, 0);

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    // lw with three wait cycles in MEMREAD: 8 cycles total
    op = LD;
    cyc();
    chk("wait_decode", outs, OD);
    cyc();
    chk("wait_memadr", outs, OMA);
    cyc();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wait_memread", outs, OMR);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("wait_memread_done", outs, OMR);
    cyc();
    chk("wait_memwb", outs, OMB);
    cyc();
    chk("wait_instret", instret, 1);
    // store never acknowledged
    op = ST;
    cyc();
    cyc();
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("tmo_memwrite0", outs, OMW);
    for (int k = 0; k < 14; k++) begin
      cyc();
      chk("tmo_memwrite", outs, OMW);
      chk("tmo_not_yet", mem_timeout, 0);
    end
    cyc();
    chk("tmo_trap", outs, 0);
    chk("tmo_flag", mem_timeout, 1);
    mem_ready = 1'b1;
`else
    chk("no_timeout", mem_timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
